reg_file_p: RTL

- Parametrised successor to the RNBIP-2 8x8 register file.
- Generalised in data width and register count, with two independently addressed registered read ports and one write port.
- The write port takes a 4-way source mux and an in-place increment/decrement/clear mode with a wrap flag.
- Sits between the operand registers (OR2), the ALU result bus, the immediate field and the memory read bus, and feeds the ALU A/B operands.

---
 rtl/reg_file_pkg.sv | 21 ++
 rtl/reg_file_wr_next.sv | 48 ++++
 rtl/reg_file_p.sv | 86 ++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared encodings and default geometry for the parametrised register file.
package reg_file_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 3;

    typedef enum logic [1:0] {
        SRC_OR2 = 2'd0,
        SRC_ALU = 2'd1,
        SRC_IMM = 2'd2,
        SRC_MEM = 2'd3
    } wr_src_e;

    typedef enum logic [1:0] {
        MODE_LOAD = 2'b00,
        MODE_INC  = 2'b01,
        MODE_DEC  = 2'b10,
        MODE_CLR  = 2'b11
    } wr_mode_e;

endpackage

// File: rtl/reg_file_wr_next.sv
// Write-value generator: source mux plus in-place INC/DEC/CLR, with wrap detect.
// Purely combinational; shared by the register write path and the read bypass.
module reg_file_wr_next
    import reg_file_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [1:0]        wr_src,
    input  logic [1:0]        wr_mode,
    input  logic [DATA_W-1:0] or2_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] mem_in,
    input  logic [DATA_W-1:0] cur_value,
    output logic [DATA_W-1:0] next_value,
    output logic              wrap
);

    logic [DATA_W-1:0] src_value;

    always_comb begin
        src_value = or2_in;
        case (wr_src_e'(wr_src))
            SRC_OR2: src_value = or2_in;
            SRC_ALU: src_value = alu_in;
            SRC_IMM: src_value = imm_in;
            SRC_MEM: src_value = mem_in;
        endcase
    end

    always_comb begin
        next_value = src_value;
        wrap       = 1'b0;
        case (wr_mode_e'(wr_mode))
            MODE_LOAD: next_value = src_value;
            MODE_INC: begin
                next_value = cur_value + DATA_W'(1);
                wrap       = &cur_value;
            end
            MODE_DEC: begin
                next_value = cur_value - DATA_W'(1);
                wrap       = ~|cur_value;
            end
            MODE_CLR: next_value = '0;
        endcase
    end

endmodule

// File: rtl/reg_file_p.sv
// NUM_REGS x DATA_W register file, 1 write port, 2 registered read ports (1-cycle latency, no backpressure).
// Define REGFILE_BYPASS_EN to forward a same-cycle write's next value to a matching read port.
module reg_file_p
    import reg_file_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter bit ZERO_REG = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] or2_in,
    input  logic [DATA_W-1:0] alu_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [DATA_W-1:0] mem_in,
    input  logic              wr_en,
    input  logic [1:0]        wr_src,
    input  logic [1:0]        wr_mode,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] dataout_A,
    output logic [DATA_W-1:0] dataout_B,
    output logic              rd_valid,
    output logic              wrap_flag
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] wr_next;
    logic              wr_wrap;
    logic              wr_accept;
    logic [DATA_W-1:0] rd_val_a;
    logic [DATA_W-1:0] rd_val_b;

    // A write to the hardwired zero register is dropped entirely, wrap_flag included.
    assign wr_accept = wr_en && !(ZERO_REG && (wr_addr == '0));

    reg_file_wr_next #(
        .DATA_W (DATA_W)
    ) u_wr_next (
        .wr_src     (wr_src),
        .wr_mode    (wr_mode),
        .or2_in     (or2_in),
        .alu_in     (alu_in),
        .imm_in     (imm_in),
        .mem_in     (mem_in),
        .cur_value  (regs[wr_addr]),
        .next_value (wr_next),
        .wrap       (wr_wrap)
    );

    always_comb begin
        rd_val_a = regs[rd_addr_a];
        rd_val_b = regs[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
        if (wr_accept && (wr_addr == rd_addr_a)) rd_val_a = wr_next;
        if (wr_accept && (wr_addr == rd_addr_b)) rd_val_b = wr_next;
`endif
        if (ZERO_REG && (rd_addr_a == '0)) rd_val_a = '0;
        if (ZERO_REG && (rd_addr_b == '0)) rd_val_b = '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            dataout_A <= '0;
            dataout_B <= '0;
            rd_valid  <= 1'b0;
            wrap_flag <= 1'b0;
        end else begin
            if (wr_accept) begin
                regs[wr_addr] <= wr_next;
                wrap_flag     <= wr_wrap;
            end
            rd_valid <= rd_en;
            if (rd_en) begin
                dataout_A <= rd_val_a;
                dataout_B <= rd_val_b;
            end
        end
    end

endmodule
